// File: rtl/multicycle_control.sv
// Multi-cycle control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// with a bounded wait on the memory handshakes, a stall freeze and a retired-instruction counter.
module multicycle_control #(
  parameter int OP_W     = 4,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             alu_zero,
  input  logic             stall,
  output logic [1:0]       IMMGENOP,
  output logic             ALUOP,
  output logic [1:0]       ALUIN1,
  output logic [1:0]       ALUIN2,
  output logic [1:0]       ALUSRC,
  output logic             IRWRITE,
  output logic             PCINC,
  output logic             PCWRITE,
  output logic             MEMREAD,
  output logic             MEMWRITE,
  output logic             MEM2REG,
  output logic             REGWRITE,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            st;
  logic [OP_W-1:0]   op_q;
  logic [WAIT_W-1:0] wait_cnt;

  // Only the low nibble is decoded; any set upper bit makes the opcode undefined.
  function automatic logic is_legal(input logic [OP_W-1:0] o);
    logic [OP_W+3:0] w;
    w = {4'b0000, o};
    return (w[OP_W+3:4] == '0) && (o[3:0] != 4'd7) && (o[3:0] != 4'd14);
  endfunction

  logic [3:0] lo;
  logic       legal_q, is_lw, is_sw, is_wri, is_rea, is_bne, is_jump, is_mem, active;

  always_comb begin
    lo      = op_q[3:0];
    legal_q = is_legal(op_q);
    is_lw   = legal_q && (lo == 4'd9);
    is_sw   = legal_q && (lo == 4'd10);
    is_wri  = legal_q && (lo == 4'd12);
    is_rea  = legal_q && (lo == 4'd13);
    is_bne  = legal_q && (lo == 4'd11);
    is_jump = legal_q && ((lo == 4'd4) || (lo == 4'd6));
    is_mem  = is_lw || is_sw || is_wri || is_rea;
    active  = !reset && !stall;
  end

  always_comb begin
    {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = 9'd0;
    if (legal_q) begin
      case (lo)
        4'd1:    {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd0, 1'b1, 2'd0, 2'd0, 2'd1};
        4'd2:    {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd0, 1'b1, 2'd0, 2'd0, 2'd0};
        4'd3:    {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd0, 1'b1, 2'd0, 2'd0, 2'd2};
        4'd4:    {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd0, 1'b0, 2'd1, 2'd1, 2'd0};
        4'd5:    {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd3, 1'b1, 2'd0, 2'd2, 2'd0};
        4'd6:    {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd2, 1'b0, 2'd1, 2'd2, 2'd0};
        4'd8, 4'd9, 4'd10:
                 {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd0, 1'b0, 2'd0, 2'd2, 2'd0};
        4'd11:   {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd2, 1'b1, 2'd1, 2'd0, 2'd0};
        4'd12, 4'd13:
                 {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd0, 1'b1, 2'd0, 2'd0, 2'd0};
        4'd15:   {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = {2'd1, 1'b1, 2'd0, 2'd2, 2'd0};
        default: {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC} = 9'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
    end else if (!stall) begin
      case (st)
        S_FETCH: begin
          if (imem_ready) begin
            st       <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            st       <= S_ERR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_q <= op;
          if (!is_legal(op)) illegal <= 1'b1;
          st <= S_EXEC;
        end
        S_EXEC: begin
          if (is_jump) begin
            st <= S_WB;
          end else if (is_bne || !legal_q) begin
            st      <= S_FETCH;
            retired <= retired + 1'b1;
          end else if (is_mem) begin
            st <= S_MEM;
          end else begin
            st <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= '0;
            if (is_lw) begin
              st <= S_WB;
            end else begin
              st      <= S_FETCH;
              retired <= retired + 1'b1;
            end
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            st       <= S_ERR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          st      <= S_FETCH;
          retired <= retired + 1'b1;
        end
        S_ERR:   st <= S_ERR;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Strobes are suppressed while stalled or held in reset so an aborted instruction emits nothing.
  always_comb begin
    IRWRITE  = 1'b0;
    PCINC    = 1'b0;
    PCWRITE  = 1'b0;
    MEMREAD  = 1'b0;
    MEMWRITE = 1'b0;
    MEM2REG  = 1'b0;
    REGWRITE = 1'b0;
    if (active) begin
      case (st)
        S_FETCH: begin
          IRWRITE = imem_ready;
          PCINC   = imem_ready;
        end
        S_EXEC:  PCWRITE = is_jump || (is_bne && !alu_zero);
        S_MEM: begin
          MEMREAD  = is_lw || is_rea;
          MEMWRITE = is_sw || is_wri;
        end
        S_WB: begin
          REGWRITE = 1'b1;
          MEM2REG  = is_lw;
        end
        default: ;
      endcase
    end
  end

  assign state = st;
  assign err   = (st == S_ERR);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction stream scored per retired instruction
// against a table-driven model, plus directed reset, stall, abort and timeout scenarios.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        imem_ready, dmem_ready, alu_zero, stall;
  logic [1:0]  IMMGENOP, ALUIN1, ALUIN2, ALUSRC;
  logic        ALUOP, IRWRITE, PCINC, PCWRITE, MEMREAD, MEMWRITE, MEM2REG, REGWRITE;
  logic [2:0]  state;
  logic        illegal, err;
  logic [15:0] retired;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .stall(stall), .IMMGENOP(IMMGENOP), .ALUOP(ALUOP), .ALUIN1(ALUIN1),
    .ALUIN2(ALUIN2), .ALUSRC(ALUSRC), .IRWRITE(IRWRITE), .PCINC(PCINC), .PCWRITE(PCWRITE),
    .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .MEM2REG(MEM2REG), .REGWRITE(REGWRITE),
    .state(state), .illegal(illegal), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc, ir, pcinc, pcw, mr, mw, rw, m2r;
    logic [8:0]  sel;
    logic        ill;
    logic [15:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [8:0]  sel_tab [16];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [15:0] last_ret = '0;
  int          a_cyc = 0, a_ir = 0, a_pcinc = 0, a_pcw = 0, a_mr = 0, a_mw = 0, a_rw = 0, a_m2r = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [8:0] mk(input int imm, input int aop, input int in1, input int in2, input int src);
    logic [1:0] a, b, c, d;
    logic       e;
    a = imm[1:0]; e = aop[0]; b = in1[1:0]; c = in2[1:0]; d = src[1:0];
    return {a, e, b, c, d};
  endfunction

  // Monitor: tallies strobes per instruction and scores it when retired moves.
  always @(negedge clk) begin
    if (mon_en) begin
      if (retired != last_ret) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_retire: got retired=%0d, expected no retirement", retired);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cycles", a_cyc, mon_e.cyc);
          chk("irwrite_cycles", a_ir, mon_e.ir);
          chk("pcinc_cycles", a_pcinc, mon_e.pcinc);
          chk("pcwrite_cycles", a_pcw, mon_e.pcw);
          chk("memread_cycles", a_mr, mon_e.mr);
          chk("memwrite_cycles", a_mw, mon_e.mw);
          chk("regwrite_cycles", a_rw, mon_e.rw);
          chk("mem2reg_cycles", a_m2r, mon_e.m2r);
          chk("selectors", {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC}, mon_e.sel);
          chk("illegal_flag", illegal, mon_e.ill);
          chk("retired_count", retired, mon_e.ret);
          $display("retired #%0d in %0d cycles, sel=%03h", retired, a_cyc, mon_e.sel);
        end
        last_ret = retired;
        a_cyc = 0; a_ir = 0; a_pcinc = 0; a_pcw = 0; a_mr = 0; a_mw = 0; a_rw = 0; a_m2r = 0;
      end
      a_cyc++;
      a_ir    += int'(IRWRITE);
      a_pcinc += int'(PCINC);
      a_pcw   += int'(PCWRITE);
      a_mr    += int'(MEMREAD);
      a_mw    += int'(MEMWRITE);
      a_rw    += int'(REGWRITE);
      a_m2r   += int'(MEM2REG);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          o, d1, d2, z, ncyc;
    bit          legal, lw, sw, wri, rea, bne, jmp, mem, wb, model_ill;
    logic [15:0] model_ret;
    exp_t        e;

    sel_tab[0]  = mk(0,0,0,0,0); sel_tab[1]  = mk(0,1,0,0,1); sel_tab[2]  = mk(0,1,0,0,0);
    sel_tab[3]  = mk(0,1,0,0,2); sel_tab[4]  = mk(0,0,1,1,0); sel_tab[5]  = mk(3,1,0,2,0);
    sel_tab[6]  = mk(2,0,1,2,0); sel_tab[7]  = mk(0,0,0,0,0); sel_tab[8]  = mk(0,0,0,2,0);
    sel_tab[9]  = mk(0,0,0,2,0); sel_tab[10] = mk(0,0,0,2,0); sel_tab[11] = mk(2,1,1,0,0);
    sel_tab[12] = mk(0,1,0,0,0); sel_tab[13] = mk(0,1,0,0,0); sel_tab[14] = mk(0,0,0,0,0);
    sel_tab[15] = mk(1,1,0,2,0);

    // Reset state, with imem_ready high to show strobes stay low under reset.
    reset = 1'b1; op = 4'd0; imem_ready = 1'b1; dmem_ready = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_retired", retired, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_err", err, 0);
    chk("reset_strobes", {IRWRITE, PCINC, PCWRITE, MEMREAD, MEMWRITE, MEM2REG, REGWRITE}, 0);
    chk("reset_selectors", {IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC}, 0);

    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b1;
    model_ret = '0; model_ill = 1'b0;

    // Random instruction stream; inputs are scheduled open-loop from the model's timing.
    for (int n = 0; n < 80; n++) begin
      o  = (n < 16) ? n : int'($urandom_range(0, 15));
      d1 = int'($urandom_range(0, 3));
      d2 = int'($urandom_range(0, 3));
      z  = int'($urandom_range(0, 1));
      legal = !(o == 7 || o == 14);
      lw = (o == 9); sw = (o == 10); wri = (o == 12); rea = (o == 13);
      bne = (o == 11); jmp = (o == 4 || o == 6);
      mem = lw || sw || wri || rea;
      wb  = legal && !bne && !sw && !wri && !rea;
      ncyc = d1 + 3 + (mem ? d2 + 1 : 0) + (wb ? 1 : 0);
      e.cyc   = ncyc;
      e.ir    = 1;
      e.pcinc = 1;
      e.pcw   = jmp ? 1 : ((bne && z == 0) ? 1 : 0);
      e.mr    = (lw || rea) ? d2 + 1 : 0;
      e.mw    = (sw || wri) ? d2 + 1 : 0;
      e.rw    = wb ? 1 : 0;
      e.m2r   = lw ? 1 : 0;
      e.sel   = sel_tab[o];
      model_ill = model_ill | !legal;
      e.ill   = model_ill;
      model_ret = model_ret + 16'd1;
      e.ret   = model_ret;
      exp_q.push_back(e);
      $display("issue op=%0d fetch_wait=%0d mem_wait=%0d zero=%0d expect %0d cycles", o, d1, d2, z, ncyc);
      op = o[3:0];
      alu_zero = z[0];
      for (int k = 0; k < ncyc; k++) begin
        imem_ready = (k == d1);
        dmem_ready = mem && (k == d1 + 3 + d2);
        @(posedge clk); #1;
      end
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Stall in MEM of sw: strobe drops, state freezes, ready seen during stall is ignored.
    reset = 1'b1; alu_zero = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; op = 4'd10; imem_ready = 1'b1;
    @(posedge clk); #1; imem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_mem_state", state, 3);
    chk("sw_memwrite", MEMWRITE, 1);
    @(posedge clk); #1; stall = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    chk("stall_memwrite", MEMWRITE, 0);
    chk("stall_state", state, 3);
    @(posedge clk); #1; dmem_ready = 1'b0;
    @(negedge clk);
    chk("stall_frozen_state", state, 3);
    @(posedge clk); #1; stall = 1'b0;
    @(negedge clk);
    chk("unstall_memwrite", MEMWRITE, 1);
    chk("unstall_state", state, 3);
    @(posedge clk); #1; dmem_ready = 1'b1;
    @(negedge clk);
    chk("sw_done_memwrite", MEMWRITE, 1);
    @(posedge clk); #1; dmem_ready = 1'b0;
    @(negedge clk);
    chk("sw_retired_state", state, 0);
    chk("sw_retired_count", retired, 1);

    // Reset mid-MEM of lw aborts it with no strobe.
    op = 4'd9; imem_ready = 1'b1;
    @(posedge clk); #1; imem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("lw_memread", MEMREAD, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_state", state, 0);
    chk("abort_strobes", {IRWRITE, PCINC, PCWRITE, MEMREAD, MEMWRITE, MEM2REG, REGWRITE}, 0);
    chk("abort_retired", retired, 0);

    // Fetch timeout: MAX_WAIT+1 FETCH cycles with imem_ready low, then ERR held until reset.
    @(posedge clk); #1;
    reset = 1'b0; imem_ready = 1'b0;
    repeat (16) @(negedge clk);
    chk("timeout_last_fetch", state, 0);
    @(negedge clk);
    chk("timeout_state", state, 5);
    chk("timeout_err", err, 1);
    imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_held_state", state, 5);
    chk("err_held_strobes", {IRWRITE, PCINC}, 0);
    reset = 1'b1;
    #1;
    chk("err_cleared_state", state, 0);
    chk("err_cleared_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
